// File: rtl/md_unit_iter_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface md_unit_iter_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output flush, start, op, d1, d2, input busy, done, hi, lo);
  modport slave  (input flush, start, op, d1, d2, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit_iter.sv
// HI/LO multiply/divide unit: fixed-latency multiply/MAC and a bit-serial restoring divider.
module md_unit_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic           clk,
  input logic           reset,
  md_unit_iter_if.slave bus
);
  localparam int CNT_MAX = (WIDTH + 1 > MUL_LAT) ? WIDTH + 1 : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [WIDTH-1:0] ONE     = 1;

  localparam logic [3:0] OP_MULTU = 4'd1, OP_MULT = 4'd2, OP_DIVU = 4'd3, OP_DIV = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5, OP_MTLO = 4'd6, OP_MADDU = 4'd7, OP_MADD = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9, OP_MSUB = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod_q;
  logic [1:0]         acc_mode;
  logic [WIDTH-1:0]   quo_q, rem_q, dvsr_q, d1_q, hi_q, lo_q;
  logic               q_neg, r_neg, done_q;

  logic issue, busy_c, mul_commit, div_step, div_commit, last_cnt;
  logic is_mul, is_div, is_signed;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? negate(mag) : mag;
  endfunction

  assign is_mul    = bus.op inside {OP_MULTU, OP_MULT, OP_MADDU, OP_MADD, OP_MSUBU, OP_MSUB};
  assign is_div    = bus.op inside {OP_DIVU, OP_DIV};
  assign is_signed = bus.op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  assign last_cnt  = (cnt == CNT_ONE);

  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u, prod_sel, hilo, acc_sum;
  logic [WIDTH-1:0]          mag1, mag2;
  logic [WIDTH:0]            rem_sh, diff;

  assign prod_s   = $signed({{WIDTH{bus.d1[WIDTH-1]}}, bus.d1}) *
                    $signed({{WIDTH{bus.d2[WIDTH-1]}}, bus.d2});
  assign prod_u   = {{WIDTH{1'b0}}, bus.d1} * {{WIDTH{1'b0}}, bus.d2};
  assign prod_sel = is_signed ? $unsigned(prod_s) : prod_u;
  assign mag1     = (is_signed && bus.d1[WIDTH-1]) ? negate(bus.d1) : bus.d1;
  assign mag2     = (is_signed && bus.d2[WIDTH-1]) ? negate(bus.d2) : bus.d2;

  assign hilo    = {hi_q, lo_q};
  assign acc_sum = (acc_mode == 2'd1) ? hilo + prod_q :
                   (acc_mode == 2'd2) ? hilo - prod_q : prod_q;

  // Restoring step: shift the next dividend bit into the partial remainder, trial-subtract.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvsr_q};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          if (is_mul)      state_nxt = S_MUL;
          else if (is_div) state_nxt = S_DIV;
        end
        S_MUL, S_DIV: if (last_cnt) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_c     = (state != S_IDLE);
    issue      = (state == S_IDLE) && bus.start && !bus.flush;
    mul_commit = (state == S_MUL) && last_cnt && !bus.flush;
    div_step   = (state == S_DIV) && !last_cnt && !bus.flush;
    div_commit = (state == S_DIV) && last_cnt && !bus.flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0; lo_q <= '0; cnt <= '0; prod_q <= '0; acc_mode <= '0;
      quo_q <= '0; rem_q <= '0; dvsr_q <= '0; d1_q <= '0;
      q_neg <= 1'b0; r_neg <= 1'b0; done_q <= 1'b0;
    end else begin
      done_q <= mul_commit | div_commit;
      if (bus.flush) begin
        cnt <= '0;
      end else if (issue) begin
        if (is_mul) begin
          prod_q   <= prod_sel;
          acc_mode <= (bus.op inside {OP_MADDU, OP_MADD}) ? 2'd1 :
                      (bus.op inside {OP_MSUBU, OP_MSUB}) ? 2'd2 : 2'd0;
          cnt      <= CNT_W'(MUL_LAT);
        end else if (is_div) begin
          quo_q  <= mag1;
          rem_q  <= '0;
          dvsr_q <= mag2;
          d1_q   <= bus.d1;
          q_neg  <= is_signed && (bus.d1[WIDTH-1] ^ bus.d2[WIDTH-1]);
          r_neg  <= is_signed && bus.d1[WIDTH-1];
          cnt    <= CNT_W'(WIDTH + 1);
        end else if (bus.op == OP_MTHI) begin
          hi_q <= bus.d1;
        end else if (bus.op == OP_MTLO) begin
          lo_q <= bus.d1;
        end
      end else if (busy_c) begin
        cnt <= cnt - CNT_ONE;
        if (mul_commit) {hi_q, lo_q} <= acc_sum;
        if (div_step) begin
          if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= rem_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        // Zero divisor reports the raw dividend rather than the magnitude the loop leaves behind.
        if (div_commit) begin
          if (dvsr_q == '0) begin
            hi_q <= d1_q;
            lo_q <= '1;
          end else begin
            hi_q <= apply_sign(rem_q, r_neg);
            lo_q <= apply_sign(quo_q, q_neg);
          end
        end
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit_iter.sv
// Directed bench for md_unit_iter: 32-bit/MUL_LAT=5 and 8-bit/MUL_LAT=1 instances.
module tb_md_unit_iter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_iter_if #(.WIDTH(32)) b32();
  md_unit_iter_if #(.WIDTH(8))  b8();

  md_unit_iter #(.WIDTH(32), .MUL_LAT(5)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  md_unit_iter #(.WIDTH(8),  .MUL_LAT(1)) dut8  (.clk(clk), .reset(reset), .bus(b8));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] hi;
    logic [31:0] lo;
    int          bc;
    int          dn;
  } vec_t;

  vec_t vt[16];
  vec_t v8[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int bc, output int dn);
    @(negedge clk);
    b32.start = 1'b1; b32.op = op; b32.d1 = a; b32.d2 = b;
    @(negedge clk);
    b32.start = 1'b0;
    bc = 0; dn = 0;
    while (b32.busy && bc < 100) begin
      bc++;
      if (b32.done) dn++;
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int bc, output int dn);
    @(negedge clk);
    b8.start = 1'b1; b8.op = op; b8.d1 = a; b8.d2 = b;
    @(negedge clk);
    b8.start = 1'b0;
    bc = 0; dn = 0;
    while (b8.busy && bc < 100) begin
      bc++;
      if (b8.done) dn++;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int bc, dn;
    logic [31:0] hi_pre;

    vt[0]  = '{4'd2,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1};
    vt[1]  = '{4'd3,  32'd100,      32'd7,        32'd2,        32'd14,       33, 1};
    vt[2]  = '{4'd4,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1};
    vt[3]  = '{4'd4,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, 1};
    vt[4]  = '{4'd3,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33, 1};
    vt[5]  = '{4'd5,  32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 0,  0};
    vt[6]  = '{4'd6,  32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 0,  0};
    vt[7]  = '{4'd7,  32'd1,        32'd1,        32'd1,        32'd0,        5,  1};
    vt[8]  = '{4'd10, 32'd2,        32'd3,        32'd0,        32'hFFFFFFFA, 5,  1};
    vt[9]  = '{4'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1};
    vt[10] = '{4'd4,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1};
    vt[11] = '{4'd4,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33, 1};
    vt[12] = '{4'd8,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFF9, 32'hFFFFFFFE, 5,  1};
    vt[13] = '{4'd9,  32'd1,        32'd2,        32'hFFFFFFF9, 32'hFFFFFFFC, 5,  1};
    vt[14] = '{4'd0,  32'd123,      32'd4,        32'hFFFFFFF9, 32'hFFFFFFFC, 0,  0};
    vt[15] = '{4'd11, 32'd123,      32'd4,        32'hFFFFFFF9, 32'hFFFFFFFC, 0,  0};

    v8[0] = '{4'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1, 1};
    v8[1] = '{4'd3, 32'd200, 32'd7, 32'd4,  32'h1C, 9, 1};
    v8[2] = '{4'd4, 32'h80, 32'hFF, 32'h00, 32'h80, 9, 1};

    b32.flush = 1'b0; b32.start = 1'b0; b32.op = '0; b32.d1 = '0; b32.d2 = '0;
    b8.flush  = 1'b0; b8.start  = 1'b0; b8.op  = '0; b8.d1  = '0; b8.d2  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_hi",   b32.hi,   0);
    check("rst_lo",   b32.lo,   0);
    check("rst_busy", b32.busy, 0);
    check("rst_done", b32.done, 0);
    check("rst8_hi",  b8.hi,    0);
    check("rst8_busy", b8.busy, 0);

    for (int i = 0; i < 16; i++) begin
      run32(vt[i].op, vt[i].d1, vt[i].d2, bc, dn);
      check($sformatf("v%0d_hi", i), b32.hi, vt[i].hi);
      check($sformatf("v%0d_lo", i), b32.lo, vt[i].lo);
      check($sformatf("v%0d_busy_cycles", i), bc, vt[i].bc);
      repeat (2) begin
        if (b32.done) dn++;
        @(negedge clk);
      end
      check($sformatf("v%0d_done_pulses", i), dn, vt[i].dn);
    end

    // Flush in the 10th busy cycle of a divide.
    run32(4'd6, 32'h1234, 32'd0, bc, dn);
    hi_pre = b32.hi;
    b32.start = 1'b1; b32.op = 4'd3; b32.d1 = 32'd9; b32.d2 = 32'd2;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", b32.busy, 1);
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0;
    check("flush_busy", b32.busy, 0);
    check("flush_lo", b32.lo, 32'h1234);
    check("flush_hi", b32.hi, hi_pre);
    dn = 0;
    repeat (40) begin
      if (b32.done) dn++;
      @(negedge clk);
    end
    check("flush_done", dn, 0);
    check("flush_lo_late", b32.lo, 32'h1234);

    // MTLO issued together with flush is dropped.
    b32.flush = 1'b1; b32.start = 1'b1; b32.op = 4'd6; b32.d1 = 32'hBEEF;
    @(negedge clk);
    b32.flush = 1'b0; b32.start = 1'b0;
    check("flush_mtlo_lo", b32.lo, 32'h1234);
    check("flush_mtlo_busy", b32.busy, 0);

    // Flush on the multiply commit cycle wins.
    b32.start = 1'b1; b32.op = 4'd2; b32.d1 = 32'd3; b32.d2 = 32'd3;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (4) @(negedge clk);
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0;
    dn = 0;
    repeat (3) begin
      if (b32.done) dn++;
      @(negedge clk);
    end
    check("flushc_lo", b32.lo, 32'h1234);
    check("flushc_busy", b32.busy, 0);
    check("flushc_done", dn, 0);

    // Start pulses while busy are ignored.
    b32.start = 1'b1; b32.op = 4'd3; b32.d1 = 32'd1000; b32.d2 = 32'd3;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (4) @(negedge clk);
    b32.start = 1'b1; b32.op = 4'd6; b32.d1 = 32'hDEAD;
    @(negedge clk);
    b32.op = 4'd2; b32.d2 = 32'd9;
    @(negedge clk);
    b32.start = 1'b0;
    bc = 6;
    while (b32.busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    check("sbusy_cycles", bc, 33);
    check("sbusy_hi", b32.hi, 32'd1);
    check("sbusy_lo", b32.lo, 32'd333);

    // Back-to-back issue in the first idle cycle.
    run32(4'd1, 32'd2, 32'd3, bc, dn);
    check("b2b_done", b32.done, 1);
    b32.start = 1'b1; b32.op = 4'd5; b32.d1 = 32'd7;
    @(negedge clk);
    b32.start = 1'b0;
    check("b2b_hi", b32.hi, 32'd7);
    check("b2b_lo", b32.lo, 32'd6);

    // Reset in the middle of a divide.
    b32.start = 1'b1; b32.op = 4'd4; b32.d1 = 32'd50; b32.d2 = 32'd3;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", b32.busy, 0);
    check("mrst_hi", b32.hi, 0);
    check("mrst_lo", b32.lo, 0);
    check("mrst_done", b32.done, 0);

    for (int i = 0; i < 3; i++) begin
      run8(v8[i].op, v8[i].d1[7:0], v8[i].d2[7:0], bc, dn);
      check($sformatf("w8_%0d_hi", i), b8.hi, v8[i].hi[7:0]);
      check($sformatf("w8_%0d_lo", i), b8.lo, v8[i].lo[7:0]);
      check($sformatf("w8_%0d_busy_cycles", i), bc, v8[i].bc);
      repeat (2) begin
        if (b8.done) dn++;
        @(negedge clk);
      end
      check($sformatf("w8_%0d_done_pulses", i), dn, v8[i].dn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
